// File: rtl/chen_pkg.sv
// Shared constants and FSM encoding for the Chen attractor DAC output stage.
package chen_pkg;

  localparam int WIDTH     = 32;  // A(11,20) state word
  localparam int FRAC_BITS = 20;

  localparam int DAC_MID = 2048;
  localparam int DAC_MAX = 4095;

  // Upper nibble of the MCP4822 command word: channel, don't-care, gain 1x, active
  localparam logic [3:0] CFG_A = 4'b0011;
  localparam logic [3:0] CFG_B = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRAME_A,
    S_GAP_A,
    S_FRAME_B,
    S_GAP_B,
    S_LDAC
  } state_t;

endpackage

// File: rtl/chen_dac_if.sv
// Sample input and SPI/DAC output bundle between the oscillator, chen_dac and the board.
interface chen_dac_if;
  import chen_pkg::*;

  logic             valid_i;
  logic [WIDTH-1:0] xn_i;
  logic [WIDTH-1:0] yn_i;
  logic [WIDTH-1:0] zn_i;
  logic             sel_b_i;
  logic             cs_n_o;
  logic             sck_o;
  logic             sdi_o;
  logic             ldac_n_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output valid_i, xn_i, yn_i, zn_i, sel_b_i,
    input  cs_n_o, sck_o, sdi_o, ldac_n_o, busy_o, done_o
  );

  modport slave (
    input  valid_i, xn_i, yn_i, zn_i, sel_b_i,
    output cs_n_o, sck_o, sdi_o, ldac_n_o, busy_o, done_o
  );

endinterface

// File: rtl/fx2dac.sv
// Fixed-point state word to 12-bit offset-binary DAC code: floor shift, +2048, clamp.
module fx2dac
  import chen_pkg::*;
#(
  parameter int SHIFT = FRAC_BITS - 5
) (
  input  logic [WIDTH-1:0] value,
  output logic [11:0]      code
);

  // One guard bit so the +2048 offset cannot wrap for any shift amount
  logic signed [WIDTH:0] shifted;
  logic signed [WIDTH:0] biased;

  // NOTE: every path assigns code, so this stays purely combinational (no latch).
  always_comb begin
    shifted = $signed({value[WIDTH-1], value}) >>> SHIFT;
    biased  = shifted + (WIDTH+1)'(DAC_MID);
    if (biased < 0)
      code = '0;
    else if (biased > DAC_MAX)
      code = 12'(DAC_MAX);
    else
      code = biased[11:0];
  end

endmodule

// File: rtl/chen_dac.sv
// Chen attractor DAC stage: two SPI frames to an MCP4822 then an LDAC strobe.
// Optional overrun counter port enabled by defining CHEN_DAC_OVERRUN_CNT_EN.
module chen_dac
  import chen_pkg::*;
#(
  parameter int SHIFT   = FRAC_BITS - 5,
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  chen_dac_if.slave   bus
`ifdef CHEN_DAC_OVERRUN_CNT_EN
  ,
  output logic [15:0] overrun_o
`endif
);

  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             sck_hi_q, sck_hi_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [11:0]      code_b_q, code_b_d;

  logic             cs_n_q, sck_q, sdi_q, ldac_n_q, busy_q, done_q;
  logic             cs_n_d, sck_d, sdi_d, ldac_n_d, busy_d, done_d;

  logic [WIDTH-1:0] src_b;
  logic [11:0]      code_a_in, code_b_in;
  logic             div_last;
  logic             is_frame;

  assign src_b    = bus.sel_b_i ? bus.zn_i : bus.yn_i;
  assign div_last = (div_q == DIV_LAST);

  fx2dac #(.SHIFT(SHIFT)) u_fx2dac_a (.value(bus.xn_i), .code(code_a_in));
  fx2dac #(.SHIFT(SHIFT)) u_fx2dac_b (.value(src_b),    .code(code_b_in));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      sck_hi_q <= 1'b0;
      bit_q    <= '0;
      shreg_q  <= '0;
      code_b_q <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of its peers.
      state_q  <= state_d;
      div_q    <= div_d;
      sck_hi_q <= sck_hi_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      code_b_q <= code_b_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      sdi_q    <= sdi_d;
      ldac_n_q <= ldac_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sck_hi_d = sck_hi_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    code_b_d = code_b_q;
    if (state_q != S_IDLE)
      div_d = div_last ? '0 : div_q + CNT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (bus.valid_i) begin
          state_d  = S_FRAME_A;
          shreg_d  = {CFG_A, code_a_in};
          code_b_d = code_b_in;
        end
      end
      S_FRAME_A, S_FRAME_B: begin
        if (div_last) begin
          sck_hi_d = ~sck_hi_q;
          // End of a high half: advance to the next bit; the 4-bit counter wraps to 0
          if (sck_hi_q) begin
            bit_d   = bit_q + 4'd1;
            shreg_d = {shreg_q[14:0], 1'b0};
            if (bit_q == 4'd15)
              state_d = (state_q == S_FRAME_A) ? S_GAP_A : S_GAP_B;
          end
        end
      end
      S_GAP_A: begin
        if (div_last) begin
          state_d = S_FRAME_B;
          shreg_d = {CFG_B, code_b_q};
        end
      end
      S_GAP_B: if (div_last) state_d = S_LDAC;
      S_LDAC:  if (div_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state
  always_comb begin
    is_frame = (state_d == S_FRAME_A) || (state_d == S_FRAME_B);
    cs_n_d   = ~is_frame;
    sck_d    = is_frame & sck_hi_d;
    sdi_d    = is_frame & shreg_d[15];
    ldac_n_d = (state_d != S_LDAC);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_LDAC) && (div_d == DIV_LAST);
  end

  assign bus.cs_n_o   = cs_n_q;
  assign bus.sck_o    = sck_q;
  assign bus.sdi_o    = sdi_q;
  assign bus.ldac_n_o = ldac_n_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;

`ifdef CHEN_DAC_OVERRUN_CNT_EN
  logic [15:0] overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      overrun_q <= '0;
    else if (bus.valid_i && (state_q != S_IDLE) && (overrun_q != 16'hFFFF))
      overrun_q <= overrun_q + 16'd1;
  end

  assign overrun_o = overrun_q;
`endif

endmodule

// File: tb/tb_chen_dac.sv
// Directed bench for chen_dac: SPI word decode, timing, drop, reset and ClkDiv=1 builds.
module tb_chen_dac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  chen_dac_if bus ();
  chen_dac_if bus1 ();

`ifdef CHEN_DAC_OVERRUN_CNT_EN
  logic [15:0] ovr0, ovr1;
`endif

  chen_dac #(.CLK_DIV(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
`ifdef CHEN_DAC_OVERRUN_CNT_EN
    , .overrun_o(ovr0)
`endif
  );

  chen_dac #(.CLK_DIV(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
`ifdef CHEN_DAC_OVERRUN_CNT_EN
    , .overrun_o(ovr1)
`endif
  );

  always #5 clk = ~clk;

  // Observations from the most recent transfer
  logic [15:0] w [4];
  int          rises [4];
  int          cs_len [4];
  int          nwords, ldac_pulses, ldac_low, busy_cyc, done_cyc;
  logic        snap_cs, snap_sck, snap_busy, snap_ldac;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] x, y, z, input logic sel);
    if (d == 0) begin
      bus.valid_i = v;  bus.xn_i = x;  bus.yn_i = y;  bus.zn_i = z;  bus.sel_b_i = sel;
    end else begin
      bus1.valid_i = v; bus1.xn_i = x; bus1.yn_i = y; bus1.zn_i = z; bus1.sel_b_i = sel;
    end
  endtask

  // Issue one sample at edge 0 and watch ncyc cycles; cycle n is observed after edge n-1..n.
  // inj_at / inj_done add extra valid pulses, rst_at pulses reset sampled at edge rst_at.
  task automatic xfer(input int d, input logic [31:0] x, y, z, input logic sel,
                      input int inj_at, input bit inj_done, input int rst_at, input int ncyc);
    logic        cs, sck, sdi, ldac, busy, done, v;
    logic        pcs, psck, pldac;
    logic [15:0] sh;
    int          nb, len;
    pcs = 1'b1; psck = 1'b0; pldac = 1'b1; sh = '0; nb = 0; len = 0;
    nwords = 0; ldac_pulses = 0; ldac_low = 0; busy_cyc = 0; done_cyc = 0;
    for (int i = 0; i < 4; i++) begin w[i] = '0; rises[i] = 0; cs_len[i] = 0; end
    @(negedge clk);
    drive(d, 1'b1, x, y, z, sel);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (d == 0) begin
        cs = bus.cs_n_o;  sck = bus.sck_o;  sdi = bus.sdi_o;
        ldac = bus.ldac_n_o;  busy = bus.busy_o;  done = bus.done_o;
      end else begin
        cs = bus1.cs_n_o; sck = bus1.sck_o; sdi = bus1.sdi_o;
        ldac = bus1.ldac_n_o; busy = bus1.busy_o; done = bus1.done_o;
      end
      if (pcs && !cs) begin sh = '0; nb = 0; len = 0; end
      if (!cs) begin
        len++;
        if (sck && !psck) begin sh = {sh[14:0], sdi}; nb++; end
      end
      if (!pcs && cs && nwords < 4) begin
        w[nwords] = sh; rises[nwords] = nb; cs_len[nwords] = len; nwords++;
      end
      if (!ldac) ldac_low++;
      if (pldac && !ldac) ldac_pulses++;
      if (busy) busy_cyc++;
      if (done && done_cyc == 0) done_cyc = n;
      if (n == rst_at + 1) begin
        snap_cs = cs; snap_sck = sck; snap_busy = busy; snap_ldac = ldac;
      end
      pcs = cs; psck = sck; pldac = ldac;
      // Junk data after edge 0 exposes any recapture of dropped samples
      v = (n == inj_at) || (inj_done && done);
      drive(d, v, 32'h0640_0000, 32'hF9C0_0000, 32'hF9C0_0000, ~sel);
      rst = (n == rst_at);
    end
  endtask

  initial begin
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n",   bus.cs_n_o,   1'b1);
    check("rst_sck",    bus.sck_o,    1'b0);
    check("rst_sdi",    bus.sdi_o,    1'b0);
    check("rst_ldac_n", bus.ldac_n_o, 1'b1);
    check("rst_busy",   bus.busy_o,   1'b0);
    check("rst_done",   bus.done_o,   1'b0);
`ifdef CHEN_DAC_OVERRUN_CNT_EN
    check("rst_overrun", ovr0, 16'd0);
`endif
    rst = 1'b0;

    // 0.0 / +1.0
    xfer(0, 32'h0000_0000, 32'h0010_0000, 32'h0, 1'b0, -1, 1'b0, -1, 280);
    check("t1_nwords", nwords, 2);
    check("t1_word_a", w[0], 16'h3800);
    check("t1_word_b", w[1], 16'hB820);
    check("t1_rises_a", rises[0], 16);
    check("t1_cs_len_a", cs_len[0], 128);
    check("t1_cs_len_b", cs_len[1], 128);
    check("t1_ldac_pulses", ldac_pulses, 1);
    check("t1_ldac_low", ldac_low, 4);
    check("t1_done_cyc", done_cyc, 268);
    check("t1_busy_cyc", busy_cyc, 268);

    // -1.0 / z=+100.0 saturates high
    xfer(0, 32'hFFF0_0000, 32'h0, 32'h0640_0000, 1'b1, -1, 1'b0, -1, 280);
    check("t2_word_a", w[0], 16'h37E0);
    check("t2_word_b", w[1], 16'hBFFF);

    // -100.0 saturates low; largest in-range value maps exactly to 4095
    xfer(0, 32'hF9C0_0000, 32'h0, 32'h0, 1'b0, -1, 1'b0, -1, 280);
    check("t3_word_a_sat_lo", w[0], 16'h3000);
    check("t3_word_b_zero", w[1], 16'hB800);
    xfer(0, 32'h03FF_FFFF, 32'h0, 32'h0, 1'b0, -1, 1'b0, -1, 280);
    check("t3_word_a_4095", w[0], 16'h3FFF);

    // Drops: valid at cycle 10 and on the done cycle
    xfer(0, 32'h0010_0000, 32'hFFF0_0000, 32'h0, 1'b0, 10, 1'b1, -1, 280);
    check("t4_nwords", nwords, 2);
    check("t4_word_a", w[0], 16'h3820);
    check("t4_word_b", w[1], 16'hB7E0);
    check("t4_busy_cyc", busy_cyc, 268);
    check("t4_ldac_pulses", ldac_pulses, 1);
`ifdef CHEN_DAC_OVERRUN_CNT_EN
    check("t4_overrun", ovr0, 16'd2);
`endif

    // Reset mid FRAME_A
    xfer(0, 32'hFFF0_0000, 32'h0010_0000, 32'h0, 1'b0, -1, 1'b0, 50, 70);
    check("t5_rst_cs_n", snap_cs, 1'b1);
    check("t5_rst_sck", snap_sck, 1'b0);
    check("t5_rst_busy", snap_busy, 1'b0);
    check("t5_rst_ldac_n", snap_ldac, 1'b1);
    check("t5_no_ldac", ldac_pulses, 0);
    check("t5_busy_cyc", busy_cyc, 50);
`ifdef CHEN_DAC_OVERRUN_CNT_EN
    check("t5_overrun_cleared", ovr0, 16'd0);
`endif
    xfer(0, 32'hFFF0_0000, 32'h0010_0000, 32'h0, 1'b0, -1, 1'b0, -1, 280);
    check("t5_fresh_word_a", w[0], 16'h37E0);
    check("t5_fresh_word_b", w[1], 16'hB820);
    check("t5_fresh_ldac", ldac_pulses, 1);
    check("t5_fresh_done_cyc", done_cyc, 268);

    // ClkDiv = 1 instance
    xfer(1, 32'h0010_0000, 32'hFFF0_0000, 32'h0, 1'b0, -1, 1'b0, -1, 80);
    check("t6_word_a", w[0], 16'h3820);
    check("t6_word_b", w[1], 16'hB7E0);
    check("t6_rises_a", rises[0], 16);
    check("t6_rises_b", rises[1], 16);
    check("t6_cs_len_a", cs_len[0], 32);
    check("t6_busy_cyc", busy_cyc, 67);
    check("t6_done_cyc", done_cyc, 67);
    check("t6_ldac_low", ldac_low, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/chen_dac.md
# chen_dac

Downstream output stage of the Chen attractor generator. Each time the oscillator presents a new state, this block converts two of its 32-bit A(11,20) state variables to 12-bit offset-binary DAC codes, with saturation. It then transmits them as two 16-bit SPI frames to an MCP4822-class dual DAC and pulses LDAC so both channels update together, giving an oscilloscope X-Y display of the attractor.

## Interface
- Width, 32, state word width; format A(11,20): sign, 11 integer, 20 fraction bits
- Shift, 15, arithmetic right shift applied before offset; 1 code = 2^-5 with the default, span ±64.0
- ClkDiv, 4, clk_i cycles per SCK half-period (≥1)

- clk_i  input  1  system clock; only clock
- rst_i  input  1  synchronous, active-high reset
- valid_i  input  1  one-cycle pulse: new sample on xn_i/yn_i/zn_i (driven by the oscillator's enable)
- xn_i  input  Width  x state, to channel A
- yn_i  input  Width  y state, to channel B when sel_b_i=0
- zn_i  input  Width  z state, to channel B when sel_b_i=1
- sel_b_i  input  1  channel B source select, sampled with valid_i
- cs_n_o  output  1  SPI chip select, active low
- sck_o  output  1  SPI clock, mode 0 (idle low)
- sdi_o  output  1  SPI data, MSB first
- ldac_n_o  output  1  DAC latch strobe, active low
- busy_o  output  1  high whenever FSM not in IDLE
- done_o  output  1  one-cycle pulse on last LDAC cycle

## Operation
- Conversion per channel: v = value >>> Shift (signed, floor); code = v + 2048; clamp to [0, 4095].
- Frame word: bit15 = channel (0 = A, 1 = B), bit14 = 0, bit13 = 1 (gain 1x), bit12 = 1 (active), bits11:0 = code.
- States: IDLE, FRAME_A, GAP_A, FRAME_B, GAP_B, LDAC.
- In IDLE, valid_i captures both codes into registers and sel_b_i selects the B source; the next state is FRAME_A.
- FRAME_x: cs_n_o low. 16 bit periods of 2·ClkDiv cycles each. sdi_o is updated at the start of each bit period. sck_o is low for the first ClkDiv cycles and high for the second ClkDiv cycles.
- GAP_x: cs_n_o high, sck_o low, for ClkDiv cycles.
- LDAC: ldac_n_o low for ClkDiv cycles. done_o is asserted on the last of those cycles. The FSM then returns to IDLE.
- valid_i while busy_o=1 is dropped; captured data is never overwritten mid-transfer. This includes valid_i on the done_o cycle.
- All outputs are registered.

## Timing
- Reset values: cs_n_o=1, sck_o=0, sdi_o=0, ldac_n_o=1, busy_o=0, done_o=0, FSM=IDLE, capture registers 0.
- valid_i is sampled at edge 0. From cycle 1:
  - cs_n_o is low for 32·ClkDiv cycles.
  - It is then high for ClkDiv cycles.
  - It is then low for 32·ClkDiv cycles.
  - It is then high for ClkDiv cycles.
  - ldac_n_o is then low for ClkDiv cycles.
- Total busy duration is 67·ClkDiv cycles (268 with the default).
- The first sdi_o bit is valid in cycle 1, ClkDiv cycles before the first sck_o rising edge.
- Reset at any point, including mid-frame, forces all reset values at the next edge. The partial frame is abandoned and no LDAC is issued.
- The maximum sustained sample rate is one per 67·ClkDiv + 1 cycles. The oscillator's step rate must be at or below this.

## Configuration
- CHEN_DAC_OVERRUN_CNT_EN defined:
  - Adds output overrun_o [15:0], a saturating count (stops at 0xFFFF) of valid_i pulses dropped while busy.
  - Reset value of overrun_o is 0.
- CHEN_DAC_OVERRUN_CNT_EN undefined:
  - No port and no counter.
  - Drops are silent; all other behaviour is identical.

## Structure
- Package chen_pkg holds:
  - Width and FRAC_BITS = 20
  - DAC constants: DAC_MID = 2048, DAC_MAX = 4095, config nibbles 4'b0011 (A) and 4'b1011 (B)
  - the FSM state encoding
- Sub-module fx2dac: combinational shift, offset and clamp; instantiated twice, once for channel A and once for channel B.
- Top level holds the FSM, the SCK divider counter, the 4-bit bit counter, the 16-bit shift register and the optional overrun counter.

## Test plan
- Reset, then valid_i with xn=0x00000000, yn=0x00100000 (+1.0), sel_b=0 → SPI words 0x3800 then 0xB820; one ldac_n_o pulse; done_o at cycle 268.
- xn=0xFFF00000 (−1.0), zn=0x06400000 (+100.0), sel_b=1 → 0x37E0, then 0xBFFF (saturated high).
- xn=0xF9C00000 (−100.0) → 0x3000 (saturated low); xn=0x03FFFFFF → 0x3FFF; boundary code 4095 is exact.
- Second valid_i 10 cycles after the first, plus valid_i on the done_o cycle → both dropped; the first transfer's words are unchanged. With CHEN_DAC_OVERRUN_CNT_EN, overrun_o = 2.
- rst_i pulsed at cycle 50 of FRAME_A → next edge gives cs_n_o=1, sck_o=0, busy_o=0, no ldac pulse; a fresh valid_i then gives a complete, correct transfer.
- ClkDiv=1 build → 67-cycle transfer; the SCK period is 2 cycles; 16 rising edges per frame.
